// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder
//   Recovers the hex digits shown on a multiplexed 4-digit, common-anode
//   7-segment display by sniffing its segment and digit-select buses.
//   A bus pattern is acted on once, after it has been seen unchanged for
//   STABLE_CYCLES consecutive samples. This filters out ghosting and other
//   transitions that happen while the display scans from one digit to the next.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   seg[7:0]     active-low segments: [6:0] = g..a, [7] = dp
//   seg_common   active-low digit select, bit n low selects digit n
//   digits       recovered values, digits[4n+3:4n] = digit n
//   dp           recovered decimal points, active-high
//   valid_mask   bit n set once digit n has been written since reset
//   frame_done   1-cycle pulse when all four digits written since last pulse
//   err_code     1-cycle pulse: accepted pattern has an unknown segment code
//   err_common   1-cycle pulse: accepted pattern selects more than one digit
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic [3:0]  seg_common,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  valid_mask,
    output logic        frame_done,
    output logic        err_code,
    output logic        err_common
);

    localparam logic [3:0] SAT     = 4'(STABLE_CYCLES);
    localparam logic [3:0] SAT_M1  = 4'(STABLE_CYCLES - 1);
    localparam logic [11:0] IDLE   = 12'hFFF;   // seg = FF, common = 1111

    // {seg, seg_common} as sampled this cycle and on the cycle before.
    logic [11:0] sample;
    logic [11:0] prev;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [3:0]  seen;

    logic        same;
    logic        accept;

    logic [7:0]  s_seg;
    logic [3:0]  s_com;
    logic [2:0]  n_low;
    logic [1:0]  idx;
    logic        code_ok;
    logic [3:0]  code_val;

    assign s_seg = sample[11:4];
    assign s_com = sample[3:0];
    assign same  = (sample == prev);

    // The counter reaches SAT on exactly one edge per stable run, so that
    // edge is the accept. Once saturated, it stays at SAT and does not
    // trigger a second accept.
    always_comb begin
        cnt_next = cnt;
        if (!same)
            cnt_next = 4'd1;
        else if (cnt != SAT)
            cnt_next = cnt + 4'd1;
    end

    assign accept = same && (cnt == SAT_M1);

    // Count how many digit selects are low.
    always_comb begin
        n_low = 3'd0;
        for (int i = 0; i < 4; i++)
            n_low = n_low + {2'b00, ~s_com[i]};
    end

    // Digit index. This result is only used when exactly one select is low.
    always_comb begin
        idx = 2'd0;
        case (s_com)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Segment code to hex value. The code is active low (g..a).
    always_comb begin
        code_ok  = 1'b1;
        code_val = 4'h0;
        case (s_seg[6:0])
            7'h40: code_val = 4'h0;
            7'h79: code_val = 4'h1;
            7'h24: code_val = 4'h2;
            7'h30: code_val = 4'h3;
            7'h19: code_val = 4'h4;
            7'h12: code_val = 4'h5;
            7'h02: code_val = 4'h6;
            7'h78: code_val = 4'h7;
            7'h00: code_val = 4'h8;
            7'h10: code_val = 4'h9;
            7'h08: code_val = 4'hA;
            7'h03: code_val = 4'hB;
            7'h46: code_val = 4'hC;
            7'h21: code_val = 4'hD;
            7'h06: code_val = 4'hE;
            7'h0E: code_val = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= IDLE;
            prev   <= IDLE;
            cnt    <= 4'd0;
        end else begin
            sample <= {seg, seg_common};
            prev   <= sample;
            cnt    <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits     <= 16'h0;
            dp         <= 4'h0;
            valid_mask <= 4'h0;
            seen       <= 4'h0;
            frame_done <= 1'b0;
            err_code   <= 1'b0;
            err_common <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_code   <= 1'b0;
            err_common <= 1'b0;
            if (accept) begin
                if (n_low > 3'd1) begin
                    err_common <= 1'b1;
                end else if (n_low == 3'd1) begin
                    if (!code_ok) begin
                        err_code <= 1'b1;
                    end else begin
                        digits[idx*4 +: 4] <= code_val;
                        dp[idx]            <= ~s_seg[7];
                        valid_mask[idx]    <= 1'b1;
                        // The write that completes the frame also restarts
                        // the next frame.
                        if ((seen | (4'b0001 << idx)) == 4'hF) begin
                            frame_done <= 1'b1;
                            seen       <= 4'h0;
                        end else begin
                            seen <= seen | (4'b0001 << idx);
                        end
                    end
                end
                // No select low (blank): nothing changes.
            end
        end
    end

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a pattern is accepted; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg  input  8  active-low segment bus; seg[6:0] = g..a, seg[7] = dp.
REQ-005 seg_common  input  4  active-low digit-select (common anode); bit n low selects digit n.
REQ-006 digits  output  16  recovered hex values; digits[4n+3:4n] = digit n.
REQ-007 dp  output  4  recovered decimal point per digit, active-high.
REQ-008 valid_mask  output  4  bit n high once digit n has been written since reset.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been written since the last pulse or reset.
REQ-010 err_code  output  1  one-cycle pulse when an accepted pattern has an unrecognised seg[6:0] code.
REQ-011 err_common  output  1  one-cycle pulse when an accepted pattern has more than one seg_common bit low.

Function
REQ-012 {seg, seg_common} SHALL be registered into a sample register every cycle; all decoding SHALL use only the sample register.
REQ-013 A saturating stability counter SHALL be set to 1 when the sample differs from the previous sample, increment when equal, and saturate at STABLE_CYCLES.
REQ-014 A pattern SHALL be accepted exactly once, in the cycle the counter reaches STABLE_CYCLES; holding the pattern longer SHALL NOT cause a re-accept.
REQ-015 Latency: if a pattern is present at the inputs from edge E0 onward, its outputs and pulses SHALL become visible after edge E0+STABLE_CYCLES.
REQ-016 Digit index decode: 1110->0, 1101->1, 1011->2, 0111->3.
REQ-017 seg_common = 1111 (blank) on accept: no output change, no error pulse.
REQ-018 Two or more seg_common bits low on accept: err_common SHALL pulse; digits, dp, and valid_mask SHALL be unchanged.
REQ-019 seg[6:0] to value mapping: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex).
REQ-020 Valid code with a single common low: the indexed digit SHALL take the value, dp[n] SHALL take ~seg[7], and valid_mask[n] and seen[n] SHALL be set.
REQ-021 Any other seg[6:0] with a single common low: err_code SHALL pulse and the slot SHALL be unchanged.
REQ-022 An internal seen[3:0] register SHALL track digits written in the current frame.
REQ-023 When a write makes seen equal 1111, frame_done SHALL pulse in the same cycle as that write becomes visible, and seen SHALL clear to 0000 in that cycle.
REQ-024 Rewriting an already-seen digit SHALL update its value without affecting frame_done.
REQ-025 err_code, err_common, and frame_done SHALL be mutually exclusive per accept, and each SHALL be high for exactly one cycle.

Reset
REQ-026 On reset, the following SHALL clear to 0: digits, dp, valid_mask, seen, frame_done, err_code, err_common, and the stability counter.
REQ-027 On reset, the sample register SHALL load seg = FF and seg_common = 1111.
REQ-028 Reset asserted mid-run SHALL discard partial stability and frame progress.
REQ-029 A pattern held through reset release SHALL be accepted STABLE_CYCLES edges after the first non-reset edge.

Verification
REQ-030 Hold seg = A4, seg_common = 1011 for 6 cycles -> after edge E0+4, digits[11:8] = 2, dp[2] = 0, valid_mask = 0100; no pulses; no re-accept at cycles 5-6.
REQ-031 Scan digits 0..3 with values 1, 2, 3, 4 (seg F9/A4/B0/99), each held 5 cycles -> digits = 16'h4321, valid_mask = 1111, one frame_done pulse coincident with the digit-3 update, and seen cleared.
REQ-032 seg = 7F with seg_common = 1110 held 4 cycles -> err_code single pulse; digit 0 unchanged. seg_common = 1100 held 4 cycles -> err_common single pulse.
REQ-033 Glitch: seg = C0, seg_common = 1110 for 3 cycles, then 1 cycle of 1101, then 1110 again -> no accept until 4 further stable cycles.
REQ-034 Assert reset after 3 of 4 digits are written -> all outputs 0. Then scan all 4 digits -> frame_done occurs only after all 4 post-reset writes.
REQ-035 seg = 40 (C0 with dp active), seg_common = 0111 -> digits[15:12] = 0 and dp[3] = 1.
